// File: rtl/demux_dispatcher_pkg.sv
// Shared types and helpers for the demux dispatcher and its checkers.
`default_nettype none

package demux_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // One-hot decode of a channel index; zero when the index is outside 0..nch-1.
  function automatic logic [31:0] onehot(input logic [31:0] sel, input int unsigned nch);
    logic [31:0] v;
    v = '0;
    if (sel < nch) v = 32'd1 << sel;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_skid_buf.sv
// Two-entry output/skid buffer: holds {data, dest} words until the addressed
// channel accepts, sustaining one word per cycle under backpressure.
`default_nettype none

module dispatch_skid_buf
  import demux_dispatcher_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0] i_dest,
  input  logic [NCH-1:0]   i_ch_ready,
  output logic [WIDTH-1:0] o_din,
  output logic [SEL_W-1:0] o_sel,
  output logic [NCH-1:0]   o_ch_valid
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_or_data;
  logic [SEL_W-1:0] r_or_dest;
  logic [WIDTH-1:0] r_sk_data;
  logic [SEL_W-1:0] r_sk_dest;

  logic w_push;
  logic w_drain;
  logic w_ld_or_in;
  logic w_ld_or_sk;
  logic w_ld_sk;

  // Ready is a pure state decode so upstream never sees a combinational path.
  assign o_ready    = (r_state != ST_FULL);
  assign w_push     = i_valid && o_ready;
  assign o_ch_valid = (r_state != ST_EMPTY) ? NCH'(onehot(32'(r_or_dest), NCH)) : '0;
  assign w_drain    = |(o_ch_valid & i_ch_ready);
  assign o_din      = r_or_data;
  assign o_sel      = r_or_dest;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_or_in  = 1'b0;
    w_ld_or_sk  = 1'b0;
    w_ld_sk     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_ld_or_in  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && w_drain) begin
          w_ld_or_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_FULL;
          w_ld_sk     = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_state_nxt = ST_ONE;
          w_ld_or_sk  = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_or_data <= '0;
      r_or_dest <= '0;
      r_sk_data <= '0;
      r_sk_dest <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_or_in) begin
        r_or_data <= i_data;
        r_or_dest <= i_dest;
      end else if (w_ld_or_sk) begin
        r_or_data <= r_sk_data;
        r_or_dest <= r_sk_dest;
      end
      if (w_ld_sk) begin
        r_sk_data <= i_data;
        r_sk_dest <= i_dest;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_dispatcher.sv
// Upstream feeder for the demux: resolves each word's channel (tag or
// round-robin), drops out-of-range words and buffers the rest.
`default_nettype none

module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [SEL_W-1:0] i_in_dest,
  input  logic             i_in_dest_en,
  input  logic [NCH-1:0]   i_ch_ready,
  output logic [WIDTH-1:0] o_din,
  output logic [SEL_W-1:0] o_sel,
  output logic [NCH-1:0]   o_ch_valid,
  output logic             o_err_drop
);

  logic [SEL_W-1:0] r_rr;
  logic             r_err_drop;
  logic [SEL_W-1:0] w_dest;
  logic             w_in_range;
  logic             w_accept;
  logic             w_rr_last;

  assign w_dest     = i_in_dest_en ? i_in_dest : r_rr;
  assign w_in_range = (32'(w_dest) < 32'(NCH));
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_rr_last  = (32'(r_rr) == 32'(NCH - 1));
  assign o_err_drop = r_err_drop;

  // Out-of-range words complete the handshake here but never reach the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_err_drop <= 1'b0;
    end else begin
      r_err_drop <= w_accept && !w_in_range;
      if (w_accept && !i_in_dest_en) begin
        r_rr <= w_rr_last ? '0 : r_rr + 1'b1;
      end
    end
  end

  dispatch_skid_buf #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_in_valid && w_in_range),
    .o_ready    (o_in_ready),
    .i_data     (i_in_data),
    .i_dest     (w_dest),
    .i_ch_ready (i_ch_ready),
    .o_din      (o_din),
    .o_sel      (o_sel),
    .o_ch_valid (o_ch_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher (NCH=4 main instance, NCH=3 for drops).
`default_nettype none

module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_dest_en = 1'b0;
  logic [1:0] in_data = '0, in_dest = '0;
  logic [3:0] ch_ready = '0;
  logic       in_ready, err_drop;
  logic [1:0] din, sel;
  logic [3:0] ch_valid;

  logic       in_valid3 = 1'b0, in_dest_en3 = 1'b0;
  logic [1:0] in_data3 = '0, in_dest3 = '0;
  logic [2:0] ch_ready3 = '0;
  logic       in_ready3, err_drop3;
  logic [1:0] din3, sel3;
  logic [2:0] ch_valid3;

  always #5 clk = ~clk;

  demux_dispatcher #(.WIDTH(2), .NCH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_dest(in_dest), .i_in_dest_en(in_dest_en),
    .i_ch_ready(ch_ready), .o_din(din), .o_sel(sel), .o_ch_valid(ch_valid),
    .o_err_drop(err_drop));

  demux_dispatcher #(.WIDTH(2), .NCH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid3), .o_in_ready(in_ready3),
    .i_in_data(in_data3), .i_in_dest(in_dest3), .i_in_dest_en(in_dest_en3),
    .i_ch_ready(ch_ready3), .o_din(din3), .o_sel(sel3), .o_ch_valid(ch_valid3),
    .o_err_drop(err_drop3));

  typedef struct {
    logic [1:0] data;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   rr_m = 0;
  int   n_checks = 0, n_pass = 0;
  int   accepted = 0, delivered = 0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_din, prev_sel;
  logic [3:0] prev_cv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees the values
  // that will be sampled at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("ready_vs_occupancy", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      check("valid_vs_occupancy", {31'd0, ch_valid != 4'd0}, {31'd0, exp_q.size() != 0});
      check("err_drop_nch4", {31'd0, err_drop}, 32'd0);
      if (prev_stall) begin
        check("stable_din", {30'd0, din}, {30'd0, prev_din});
        check("stable_sel", {30'd0, sel}, {30'd0, prev_sel});
        check("stable_ch_valid", {28'd0, ch_valid}, {28'd0, prev_cv});
      end
      if (ch_valid != 4'd0 && ch_ready[sel]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_din", {30'd0, din}, {30'd0, e.data});
          check("sb_sel", {30'd0, sel}, {30'd0, e.sel});
          check("sb_ch_valid", {28'd0, ch_valid}, 32'd1 << e.sel);
        end
        delivered++;
      end
      prev_stall = (ch_valid != 4'd0) && !ch_ready[sel];
      prev_din   = din;
      prev_sel   = sel;
      prev_cv    = ch_valid;
      if (in_valid && in_ready) begin
        e.data = in_data;
        e.sel  = in_dest_en ? in_dest : 2'(rr_m);
        if (!in_dest_en) rr_m = (rr_m + 1) % 4;
        exp_q.push_back(e);
        accepted++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || ch_valid != 4'd0) && n < 50) begin
      step();
      n++;
    end
    check(name, {31'd0, n < 50}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_data [5];
    int d0, stalls;
    rr_data[0] = 2'b01; rr_data[1] = 2'b10; rr_data[2] = 2'b11;
    rr_data[3] = 2'b00; rr_data[4] = 2'b01;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_din", {30'd0, din}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_ch_valid", {28'd0, ch_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_err_drop", {31'd0, err_drop}, 32'd0);
    step();

    // Round-robin streaming with wrap
    ch_ready = 4'b1111; in_dest_en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = rr_data[i];
      check("rr_no_stall", {31'd0, in_ready}, 32'd1);
      step();
      check("rr_sel", {30'd0, sel}, i % 4);
      check("rr_ch_valid", {28'd0, ch_valid}, 32'd1 << (i % 4));
      check("rr_din", {30'd0, din}, {30'd0, rr_data[i]});
    end
    in_valid = 1'b0;
    wait_empty("rr_drain");

    // Explicit destination with backpressure
    ch_ready = 4'b0000; in_dest_en = 1'b1; in_dest = 2'd2;
    in_valid = 1'b1; in_data = 2'b11; step();
    in_data = 2'b01; step();
    in_valid = 1'b0;
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_din", {30'd0, din}, 32'd3);
    check("bp_ch_valid", {28'd0, ch_valid}, 32'h4);
    step(); step();
    check("bp_hold_din", {30'd0, din}, 32'd3);
    ch_ready = 4'b0100; step();
    ch_ready = 4'b0000;
    check("bp_next_din", {30'd0, din}, 32'd1);
    check("bp_next_ch_valid", {28'd0, ch_valid}, 32'h4);
    check("bp_one_ready", {31'd0, in_ready}, 32'd1);
    ch_ready = 4'b1111;
    wait_empty("bp_drain");

    // Simultaneous accept and drain for 8 cycles
    d0 = delivered; stalls = 0;
    in_valid = 1'b1; in_dest_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 2'($urandom); in_dest = 2'($urandom);
      if (!in_ready) stalls++;
      step();
    end
    in_valid = 1'b0;
    step();
    check("stream8_stalls", stalls, 32'd0);
    check("stream8_delivered", delivered - d0, 32'd8);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      in_dest_en = 1'($urandom);
      in_dest    = 2'($urandom);
      in_data    = 2'($urandom);
      ch_ready   = 4'($urandom);
      step();
    end
    in_valid = 1'b0; ch_ready = 4'b1111;
    wait_empty("rand_drain");
    check("rand_conservation", accepted, delivered);

    // Async reset in FULL
    ch_ready = 4'b0000; in_dest_en = 1'b1; in_dest = 2'd1;
    in_valid = 1'b1; in_data = 2'b10; step();
    in_data = 2'b11; step();
    in_valid = 1'b0; in_dest_en = 1'b0;
    check("ar_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ch_valid", {28'd0, ch_valid}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check("ar_din", {30'd0, din}, 32'd0);
    exp_q.delete(); rr_m = 0; prev_stall = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 2'b01; step();
    in_valid = 1'b0;
    check("ar_sel_after", {30'd0, sel}, 32'd0);
    check("ar_ch_valid_after", {28'd0, ch_valid}, 32'h1);
    ch_ready = 4'b1111;
    wait_empty("ar_drain");

    // Out-of-range destination on the NCH=3 instance
    ch_ready3 = 3'b000; in_dest_en3 = 1'b1; in_dest3 = 2'd3; in_data3 = 2'b10;
    in_valid3 = 1'b1;
    check("oor_ready", {31'd0, in_ready3}, 32'd1);
    step();
    in_valid3 = 1'b0;
    check("oor_err_drop", {31'd0, err_drop3}, 32'd1);
    check("oor_ch_valid", {29'd0, ch_valid3}, 32'd0);
    check("oor_in_ready", {31'd0, in_ready3}, 32'd1);
    step();
    check("oor_pulse_end", {31'd0, err_drop3}, 32'd0);
    check("oor_still_empty", {29'd0, ch_valid3}, 32'd0);
    ch_ready3 = 3'b111; in_dest_en3 = 1'b0; in_valid3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data3 = 2'(i);
      step();
      check("rr3_sel", {30'd0, sel3}, i % 3);
      check("rr3_ch_valid", {29'd0, ch_valid3}, 32'd1 << (i % 3));
      check("rr3_err_drop", {31'd0, err_drop3}, 32'd0);
    end
    in_valid3 = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
